mem_arbiter: RTL and testbench
==============================

// Module: mem_arbiter
// PURPOSE
//  Shares one backing memory port between instruction fetch (IF) and data access (DM, loads/stores from MEM stage).
//  Sits between the pipeline's fetch/data paths and the unified memory model, replacing the separate icache/dcache arrays.
//  One transaction outstanding at a time. Fixed data-over-fetch priority, with a starvation bound for fetch.
//  Supports squashing an in-flight fetch on a taken branch.
// PARAMETERS
//  ADDR_W      64  address width, all ports
//  DATA_W      64  data width, all ports
//  STARVE_MAX  4   consecutive DM wins while IF waits before IF is forced to win (>=1)
// PORTS
//  clk_i        in   1       clock, all state on rising edge
//  rst_ni       in   1       synchronous reset, active low
//  if_req_i     in   1       fetch request; held with if_addr_i stable until if_gnt_o
//  if_addr_i    in   ADDR_W  fetch address
//  if_kill_i    in   1       discard the current fetch transaction (branch redirect)
//  if_gnt_o     out  1       fetch request accepted by memory (1-cycle pulse)
//  if_rvalid_o  out  1       fetch read data valid (1-cycle pulse)
//  if_rdata_o   out  DATA_W  fetch read data
//  dm_req_i     in   1       data request; held with dm_we_i/addr/wdata stable until dm_gnt_o
//  dm_we_i      in   1       1 = store, 0 = load
//  dm_addr_i    in   ADDR_W  data address
//  dm_wdata_i   in   DATA_W  store data
//  dm_gnt_o     out  1       data request accepted by memory (1-cycle pulse)
//  dm_rvalid_o  out  1       load data / store ack valid (1-cycle pulse)
//  dm_rdata_o   out  DATA_W  load data (don't-care on store ack)
//  mem_req_o    out  1       request to memory; held until mem_gnt_i
//  mem_we_o     out  1       write enable to memory
//  mem_addr_o   out  ADDR_W  memory address
//  mem_wdata_o  out  DATA_W  memory write data
//  mem_gnt_i    in   1       memory accepts request this cycle
//  mem_rvalid_i in   1       memory response (read data or write ack) this cycle
//  mem_rdata_i  in   DATA_W  memory read data
// BEHAVIOUR
//  Reset (rst_ni=0 at an edge): state IDLE, owner/drop/starve_cnt cleared.
//   All *_gnt_o, *_rvalid_o, mem_req_o, mem_we_o = 0; mem_addr_o, mem_wdata_o, *_rdata_o = 0.
//   Reset mid-transaction abandons it. A later mem_rvalid_i for it arrives in IDLE and is ignored.
//  FSM states: IDLE, REQ, RESP.
//   IDLE: if any request is present, arbitrate and register the winner (owner, we, addr, wdata); go REQ next edge.
//    No requests: stay in IDLE.
//   REQ: mem_req_o=1; mem_we/addr/wdata come from the latched registers.
//    On mem_gnt_i: owner's gnt_o=1 combinationally in the same cycle; go RESP.
//   RESP: mem_req_o=0. On mem_rvalid_i: owner's rvalid_o=1 and rdata_o=mem_rdata_i combinationally; go IDLE.
//    rvalid_o is suppressed if drop is set (drop is described under kill).
//  Latency: arbitration at cycle N, mem_req_o at N+1. Earliest gnt_o is N+1; earliest rvalid_o is N+2.
//   Earliest next arbitration is N+3.
//  mem_rvalid_i in IDLE or REQ is ignored. mem_gnt_i outside REQ is ignored.
//  Non-owner gnt_o and rvalid_o stay 0. rdata_o is 0 whenever its rvalid_o is 0.
//  Arbitration:
//   - Only DM requesting: DM wins. Only IF requesting: IF wins.
//   - Both requesting: DM wins, unless starve_cnt==STARVE_MAX, in which case IF wins.
//  starve_cnt (width clog2(STARVE_MAX+1)):
//   - increments on a DM win while if_req_i=1, saturating at STARVE_MAX;
//   - clears on an IF win, or on a DM win while if_req_i=0.
//  Kill (if_kill_i):
//   - owner=IF in REQ or RESP: sets drop. The transaction still completes on the memory side (memory needs the gnt).
//     if_gnt_o still pulses; if_rvalid_o is suppressed.
//   - owner=IF and if_kill_i in the same cycle as mem_rvalid_i: response suppressed.
//   - in IDLE: no effect. if_req_i may still be arbitrated; the redirected address is taken from if_addr_i.
//   - owner=DM: no effect.
//   - drop clears on entry to IDLE.
//  Requester dropping req before gnt after winning: the latched transaction still completes. Protocol violation; the bench asserts it never happens.
// TESTING
//  1. Reset low 2 cycles, then high; no requests -> all outputs 0, mem_req_o stays 0.
//  2. IF req addr=0x10, mem_gnt_i tied 1, rvalid 1 cycle after gnt, rdata=0xAB ->
//     mem_req_o at N+1, if_gnt_o at N+1, if_rvalid_o with 0xAB at N+2.
//  3. IF and DM both req from cycle 0 (DM load addr=0x40), STARVE_MAX=4 ->
//     DM wins arbitrations 1-4, IF wins 5th, starve_cnt returns to 0.
//  4. DM store addr=0x8 wdata=0x55; memory delays gnt 3 cycles ->
//     mem_req_o/mem_we_o/addr/wdata held stable 3 cycles; dm_gnt_o one pulse; dm_rvalid_o on the ack.
//  5. IF fetch granted; if_kill_i pulsed in RESP; rvalid arrives 2 cycles later ->
//     if_rvalid_o stays 0, FSM returns to IDLE, next IF req served normally.
//  6. rst_ni low while in RESP, mem_rvalid_i arrives after reset released ->
//     no rvalid_o on either port, state IDLE.

Source files
------------

// File: rtl/mem_arbiter.sv
// mem_arbiter
//   Shares one backing memory port between instruction fetch (IF) and data
//   access (DM). Only one transaction is outstanding at a time.
//   Data requests have priority over fetch. A saturating counter bounds how
//   many times in a row fetch can lose, and a taken branch can squash the
//   response of an in-flight fetch.
//
// Ports
//   clk_i, rst_ni                      clock, synchronous active-low reset
//   if_req_i/if_addr_i/if_kill_i       fetch request, address, squash
//   if_gnt_o/if_rvalid_o/if_rdata_o    fetch accept pulse, response pulse, data
//   dm_req_i/dm_we_i/dm_addr_i/dm_wdata_i  data request (load/store)
//   dm_gnt_o/dm_rvalid_o/dm_rdata_o    data accept pulse, response pulse, data
//   mem_req_o/mem_we_o/mem_addr_o/mem_wdata_o  request to backing memory
//   mem_gnt_i/mem_rvalid_i/mem_rdata_i memory accept, response, read data
module mem_arbiter #(
    parameter int ADDR_W     = 64,
    parameter int DATA_W     = 64,
    parameter int STARVE_MAX = 4
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              if_req_i,
    input  logic [ADDR_W-1:0] if_addr_i,
    input  logic              if_kill_i,
    output logic              if_gnt_o,
    output logic              if_rvalid_o,
    output logic [DATA_W-1:0] if_rdata_o,
    input  logic              dm_req_i,
    input  logic              dm_we_i,
    input  logic [ADDR_W-1:0] dm_addr_i,
    input  logic [DATA_W-1:0] dm_wdata_i,
    output logic              dm_gnt_o,
    output logic              dm_rvalid_o,
    output logic [DATA_W-1:0] dm_rdata_o,
    output logic              mem_req_o,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    input  logic              mem_gnt_i,
    input  logic              mem_rvalid_i,
    input  logic [DATA_W-1:0] mem_rdata_i
);

    localparam int CNT_W = $clog2(STARVE_MAX + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_MAX);

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_RESP
    } state_e;

    state_e            state_q, state_d;
    logic              owner_dm_q, owner_dm_d;  // 1 = DM owns the transaction
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              drop_q, drop_d;          // squash the pending IF response
    logic [CNT_W-1:0]  starve_q, starve_d;
    logic              if_wins;

    always_comb begin
        state_d     = state_q;
        owner_dm_d  = owner_dm_q;
        we_d        = we_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        drop_d      = drop_q;
        starve_d    = starve_q;
        if_gnt_o    = 1'b0;
        if_rvalid_o = 1'b0;
        if_rdata_o  = '0;
        dm_gnt_o    = 1'b0;
        dm_rvalid_o = 1'b0;
        dm_rdata_o  = '0;
        mem_req_o   = 1'b0;
        mem_we_o    = 1'b0;
        mem_addr_o  = '0;
        mem_wdata_o = '0;

        // Fetch wins when alone, or when it has lost STARVE_MAX times in a row.
        if_wins = if_req_i && (!dm_req_i || (starve_q == CNT_MAX));

        case (state_q)
            S_IDLE: begin
                if (if_req_i || dm_req_i) begin
                    state_d    = S_REQ;
                    owner_dm_d = !if_wins;
                    if (if_wins) begin
                        we_d     = 1'b0;
                        addr_d   = if_addr_i;
                        wdata_d  = '0;
                        starve_d = '0;
                    end else begin
                        we_d    = dm_we_i;
                        addr_d  = dm_addr_i;
                        wdata_d = dm_wdata_i;
                        // Count only losses that actually kept fetch waiting.
                        if (if_req_i) begin
                            starve_d = (starve_q == CNT_MAX) ? starve_q
                                                             : starve_q + CNT_W'(1);
                        end else begin
                            starve_d = '0;
                        end
                    end
                end
            end

            S_REQ: begin
                mem_req_o   = 1'b1;
                mem_we_o    = we_q;
                mem_addr_o  = addr_q;
                mem_wdata_o = wdata_q;
                // The memory still needs its handshake, so a killed fetch runs
                // to completion and only its response is hidden.
                if (!owner_dm_q && if_kill_i) begin
                    drop_d = 1'b1;
                end
                if (mem_gnt_i) begin
                    state_d = S_RESP;
                    if (owner_dm_q) begin
                        dm_gnt_o = 1'b1;
                    end else begin
                        if_gnt_o = 1'b1;
                    end
                end
            end

            S_RESP: begin
                if (!owner_dm_q && if_kill_i) begin
                    drop_d = 1'b1;
                end
                if (mem_rvalid_i) begin
                    state_d = S_IDLE;
                    drop_d  = 1'b0;
                    if (owner_dm_q) begin
                        dm_rvalid_o = 1'b1;
                        dm_rdata_o  = mem_rdata_i;
                    end else if (!drop_q && !if_kill_i) begin
                        if_rvalid_o = 1'b1;
                        if_rdata_o  = mem_rdata_i;
                    end
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q    <= S_IDLE;
            owner_dm_q <= 1'b0;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            drop_q     <= 1'b0;
            starve_q   <= '0;
        end else begin
            state_q    <= state_d;
            owner_dm_q <= owner_dm_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            drop_q     <= drop_d;
            starve_q   <= starve_d;
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter
//   Directed bench for mem_arbiter: a table of single transactions run with a
//   zero-wait memory, followed by hand-written multi-cycle sequences (delayed
//   grant, fetch kill, reset during a transaction).
module tb_mem_arbiter;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        if_req_i;
    logic [63:0] if_addr_i;
    logic        if_kill_i;
    logic        if_gnt_o;
    logic        if_rvalid_o;
    logic [63:0] if_rdata_o;
    logic        dm_req_i;
    logic        dm_we_i;
    logic [63:0] dm_addr_i;
    logic [63:0] dm_wdata_i;
    logic        dm_gnt_o;
    logic        dm_rvalid_o;
    logic [63:0] dm_rdata_o;
    logic        mem_req_o;
    logic        mem_we_o;
    logic [63:0] mem_addr_o;
    logic [63:0] mem_wdata_o;
    logic        mem_gnt_i;
    logic        mem_rvalid_i;
    logic [63:0] mem_rdata_i;

    int total = 0;
    int bad   = 0;

    mem_arbiter #(
        .ADDR_W    (64),
        .DATA_W    (64),
        .STARVE_MAX(4)
    ) dut (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .if_req_i    (if_req_i),
        .if_addr_i   (if_addr_i),
        .if_kill_i   (if_kill_i),
        .if_gnt_o    (if_gnt_o),
        .if_rvalid_o (if_rvalid_o),
        .if_rdata_o  (if_rdata_o),
        .dm_req_i    (dm_req_i),
        .dm_we_i     (dm_we_i),
        .dm_addr_i   (dm_addr_i),
        .dm_wdata_i  (dm_wdata_i),
        .dm_gnt_o    (dm_gnt_o),
        .dm_rvalid_o (dm_rvalid_o),
        .dm_rdata_o  (dm_rdata_o),
        .mem_req_o   (mem_req_o),
        .mem_we_o    (mem_we_o),
        .mem_addr_o  (mem_addr_o),
        .mem_wdata_o (mem_wdata_o),
        .mem_gnt_i   (mem_gnt_i),
        .mem_rvalid_i(mem_rvalid_i),
        .mem_rdata_i (mem_rdata_i)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic        if_req;
        logic [63:0] if_addr;
        logic        dm_req;
        logic        dm_we;
        logic [63:0] dm_addr;
        logic [63:0] dm_wdata;
        logic [63:0] rdata;
        logic        dm_wins;   // hand-computed arbitration result
    } vec_t;

    localparam int NV = 11;
    vec_t vecs[NV];

    function automatic vec_t mk(input logic ir, input logic [63:0] ia,
                                input logic dr, input logic dw,
                                input logic [63:0] da, input logic [63:0] dd,
                                input logic [63:0] rd, input logic dwin);
        vec_t v;
        v.if_req = ir; v.if_addr = ia; v.dm_req = dr; v.dm_we = dw;
        v.dm_addr = da; v.dm_wdata = dd; v.rdata = rd; v.dm_wins = dwin;
        return v;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk_i);
        #1;
    endtask

    // The requester that won must keep requesting while its request is on the bus.
    always @(negedge clk_i) begin
        if (rst_ni === 1'b1 && mem_req_o === 1'b1) begin
            total++;
            if (!(if_req_i || dm_req_i)) begin
                bad++;
                $display("FAIL req_held: mem_req_o=1 with no requester active");
            end
        end
    end

    task automatic check_quiet(input string tag);
        chk({tag, ".mem_req"},   mem_req_o,   1'b0);
        chk({tag, ".if_gnt"},    if_gnt_o,    1'b0);
        chk({tag, ".dm_gnt"},    dm_gnt_o,    1'b0);
        chk({tag, ".if_rvalid"}, if_rvalid_o, 1'b0);
        chk({tag, ".dm_rvalid"}, dm_rvalid_o, 1'b0);
        chk({tag, ".if_rdata"},  if_rdata_o,  64'h0);
        chk({tag, ".dm_rdata"},  dm_rdata_o,  64'h0);
    endtask

    // One transaction with zero-wait grant and a response one cycle later.
    // Entered in an IDLE cycle, returns in the next IDLE cycle.
    task automatic run_txn(input string tag, input vec_t v);
        logic [63:0] e_addr;
        logic        e_we;
        e_addr = v.dm_wins ? v.dm_addr : v.if_addr;
        e_we   = v.dm_wins & v.dm_we;
        // arbitration cycle
        if_req_i = v.if_req; if_addr_i = v.if_addr;
        dm_req_i = v.dm_req; dm_we_i = v.dm_we;
        dm_addr_i = v.dm_addr; dm_wdata_i = v.dm_wdata;
        mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0;
        #1;
        chk({tag, ".idle_req"}, mem_req_o, 1'b0);
        cyc();
        // request cycle, memory grants immediately
        mem_gnt_i = 1'b1;
        #1;
        chk({tag, ".mem_req"},  mem_req_o,  1'b1);
        chk({tag, ".mem_we"},   mem_we_o,   e_we);
        chk({tag, ".mem_addr"}, mem_addr_o, e_addr);
        if (e_we) chk({tag, ".mem_wdata"}, mem_wdata_o, v.dm_wdata);
        chk({tag, ".if_gnt"},   if_gnt_o,   !v.dm_wins);
        chk({tag, ".dm_gnt"},   dm_gnt_o,   v.dm_wins);
        cyc();
        // response cycle; winner releases its request, loser keeps waiting
        mem_gnt_i = 1'b0;
        if (v.dm_wins) dm_req_i = 1'b0; else if_req_i = 1'b0;
        mem_rvalid_i = 1'b1; mem_rdata_i = v.rdata;
        #1;
        chk({tag, ".resp_req"},  mem_req_o,   1'b0);
        chk({tag, ".if_rvalid"}, if_rvalid_o, !v.dm_wins);
        chk({tag, ".dm_rvalid"}, dm_rvalid_o, v.dm_wins);
        chk({tag, ".if_rdata"},  if_rdata_o,  v.dm_wins ? 64'h0 : v.rdata);
        chk({tag, ".dm_rdata"},  dm_rdata_o,  v.dm_wins ? v.rdata : 64'h0);
        cyc();
        mem_rvalid_i = 1'b0; mem_rdata_i = 64'h0;
    endtask

    task automatic idle_inputs();
        if_req_i = 1'b0; if_addr_i = 64'h0; if_kill_i = 1'b0;
        dm_req_i = 1'b0; dm_we_i = 1'b0; dm_addr_i = 64'h0; dm_wdata_i = 64'h0;
        mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0; mem_rdata_i = 64'h0;
    endtask

    initial begin
        // IF req, IF addr, DM req, DM we, DM addr, DM wdata, rdata, DM wins
        vecs[0]  = mk(1, 64'h10, 0, 0, 64'h0,  64'h0,    64'hAB,   0);
        vecs[1]  = mk(1, 64'h20, 1, 0, 64'h40, 64'h0,    64'h1001, 1);
        vecs[2]  = mk(1, 64'h20, 1, 0, 64'h40, 64'h0,    64'h1002, 1);
        vecs[3]  = mk(1, 64'h20, 1, 0, 64'h40, 64'h0,    64'h1003, 1);
        vecs[4]  = mk(1, 64'h20, 1, 0, 64'h40, 64'h0,    64'h1004, 1);
        vecs[5]  = mk(1, 64'h20, 1, 0, 64'h40, 64'h0,    64'h1005, 0);
        vecs[6]  = mk(1, 64'h20, 1, 0, 64'h40, 64'h0,    64'h1006, 1);
        vecs[7]  = mk(1, 64'h20, 0, 0, 64'h0,  64'h0,    64'h1007, 0);
        vecs[8]  = mk(0, 64'h0,  1, 1, 64'h80, 64'h1234, 64'h0,    1);
        vecs[9]  = mk(1, 64'h28, 1, 0, 64'h88, 64'h0,    64'h1009, 1);
        vecs[10] = mk(1, 64'h28, 0, 0, 64'h0,  64'h0,    64'h100A, 0);

        idle_inputs();

        // reset and quiet idle
        rst_ni = 1'b0;
        cyc();
        cyc();
        check_quiet("rst");
        chk("rst.mem_we",    mem_we_o,    1'b0);
        chk("rst.mem_addr",  mem_addr_o,  64'h0);
        chk("rst.mem_wdata", mem_wdata_o, 64'h0);
        rst_ni = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cyc();
            check_quiet($sformatf("idle%0d", i));
        end

        // table: single fetch, starvation run, priority cases
        for (int i = 0; i < NV; i++) begin
            run_txn($sformatf("vec%0d", i), vecs[i]);
        end
        idle_inputs();

        // store with the memory withholding its grant for 3 cycles
        dm_req_i = 1'b1; dm_we_i = 1'b1; dm_addr_i = 64'h8; dm_wdata_i = 64'h55;
        cyc();
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("stall%0d.mem_req", i),   mem_req_o,   1'b1);
            chk($sformatf("stall%0d.mem_we", i),    mem_we_o,    1'b1);
            chk($sformatf("stall%0d.mem_addr", i),  mem_addr_o,  64'h8);
            chk($sformatf("stall%0d.mem_wdata", i), mem_wdata_o, 64'h55);
            chk($sformatf("stall%0d.dm_gnt", i),    dm_gnt_o,    1'b0);
            cyc();
        end
        mem_gnt_i = 1'b1;
        #1;
        chk("stall.gnt", dm_gnt_o, 1'b1);
        cyc();
        mem_gnt_i = 1'b0; dm_req_i = 1'b0;
        #1;
        chk("stall.gnt_pulse", dm_gnt_o, 1'b0);
        chk("stall.early_rv",  dm_rvalid_o, 1'b0);
        cyc();
        mem_rvalid_i = 1'b1; mem_rdata_i = 64'h99;
        #1;
        chk("stall.ack", dm_rvalid_o, 1'b1);
        cyc();
        idle_inputs();

        // fetch killed in RESP, response arrives two cycles later
        if_req_i = 1'b1; if_addr_i = 64'h30;
        cyc();
        mem_gnt_i = 1'b1;
        #1;
        chk("kill.gnt", if_gnt_o, 1'b1);
        cyc();
        mem_gnt_i = 1'b0; if_req_i = 1'b0; if_kill_i = 1'b1;
        cyc();
        if_kill_i = 1'b0;
        cyc();
        mem_rvalid_i = 1'b1; mem_rdata_i = 64'hDEAD;
        #1;
        chk("kill.rvalid", if_rvalid_o, 1'b0);
        chk("kill.rdata",  if_rdata_o,  64'h0);
        cyc();
        idle_inputs();
        run_txn("after_kill", mk(1, 64'h38, 0, 0, 64'h0, 64'h0, 64'h77, 0));
        idle_inputs();

        // kill in REQ alongside the grant: grant still pulses, response hidden
        if_req_i = 1'b1; if_addr_i = 64'h40;
        cyc();
        mem_gnt_i = 1'b1; if_kill_i = 1'b1;
        #1;
        chk("kreq.gnt", if_gnt_o, 1'b1);
        cyc();
        mem_gnt_i = 1'b0; if_kill_i = 1'b0; if_req_i = 1'b0;
        mem_rvalid_i = 1'b1; mem_rdata_i = 64'h5A;
        #1;
        chk("kreq.rvalid", if_rvalid_o, 1'b0);
        cyc();
        idle_inputs();

        // kill coincident with the response
        if_req_i = 1'b1; if_addr_i = 64'h48;
        cyc();
        mem_gnt_i = 1'b1;
        cyc();
        mem_gnt_i = 1'b0; if_req_i = 1'b0;
        mem_rvalid_i = 1'b1; mem_rdata_i = 64'h6B; if_kill_i = 1'b1;
        #1;
        chk("kresp.rvalid", if_rvalid_o, 1'b0);
        cyc();
        idle_inputs();
        run_txn("after_kresp", mk(0, 64'h0, 1, 0, 64'h58, 64'h0, 64'h3C, 1));
        idle_inputs();

        // reset while waiting for a response; the late response is ignored
        if_req_i = 1'b1; if_addr_i = 64'h50;
        cyc();
        mem_gnt_i = 1'b1;
        cyc();
        mem_gnt_i = 1'b0; if_req_i = 1'b0;
        rst_ni = 1'b0;
        cyc();
        rst_ni = 1'b1;
        #1;
        check_quiet("rst_mid");
        cyc();
        mem_rvalid_i = 1'b1; mem_rdata_i = 64'hBAD;
        #1;
        chk("late_rv.if_rvalid", if_rvalid_o, 1'b0);
        chk("late_rv.dm_rvalid", dm_rvalid_o, 1'b0);
        chk("late_rv.mem_req",   mem_req_o,   1'b0);
        cyc();
        idle_inputs();
        run_txn("after_rst", mk(0, 64'h0, 1, 0, 64'h60, 64'h0, 64'hC0DE, 1));
        idle_inputs();
        cyc();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
